// File: rtl/router_mesh_param.sv
// Five-port input-buffered mesh router: XY dimension-order routing, per-output
// round-robin arbitration, registered outputs held while the downstream side is full.
module router_mesh_param #(
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int MESH_X         = 4,
   parameter int MESH_Y         = 2,
   parameter int ADDR_W         = 3,
   parameter int ROUTER_ADDRESS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5*DATA_WIDTH-1:0] in_data,
   input  logic [4:0]              in_valid,
   output logic [4:0]              in_full,
   output logic [5*DATA_WIDTH-1:0] out_data,
   output logic [4:0]              out_valid,
   input  logic [4:0]              out_full,
   output logic [4:0]              overflow_err,
   output logic                    route_err
);
   localparam int NP    = 5;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int NODES = MESH_X * MESH_Y;
   localparam int RX    = ROUTER_ADDRESS % MESH_X;
   localparam int RY    = ROUTER_ADDRESS / MESH_X;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0]         r_mem [NP][FIFO_DEPTH];
   logic [PW-1:0]                 r_wr_ptr [NP];
   logic [PW-1:0]                 r_rd_ptr [NP];
   logic [PW:0]                   r_count [NP];
   logic [NP-1:0][DATA_WIDTH-1:0] r_out_data;
   logic [NP-1:0]                 r_out_valid;
   logic [2:0]                    r_ptr [NP];
   logic [NP-1:0]                 r_overflow;
   logic                          r_route_err;

   logic [DATA_WIDTH-1:0] w_head [NP];
   logic [2:0]            w_route [NP];
   logic [2:0]            w_gnt_idx [NP];
   logic [NP-1:0]         w_nonempty, w_full, w_bad, w_push, w_pop, w_load, w_gnt_v;

   // Route compute on each FIFO head: X first, then Y, otherwise eject locally.
   always_comb begin
      int dst, dx, dy;
      for (int p = 0; p < NP; p++) begin
         w_head[p]     = r_mem[p][r_rd_ptr[p]];
         w_nonempty[p] = (r_count[p] != '0);
         w_full[p]     = (r_count[p] == FULL_CNT);
         w_push[p]     = in_valid[p] && !w_full[p];
         dst           = int'(w_head[p][ADDR_W-1:0]);
         dx            = dst % MESH_X;
         dy            = dst / MESH_X;
         w_bad[p]      = w_nonempty[p] && (dst >= NODES);
         if (dx > RX)      w_route[p] = 3'd1;
         else if (dx < RX) w_route[p] = 3'd2;
         else if (dy > RY) w_route[p] = 3'd3;
         else if (dy < RY) w_route[p] = 3'd4;
         else              w_route[p] = 3'd0;
      end
   end

   // Per-output round-robin; search starts just after the last winner.
   always_comb begin
      logic [2:0] idx;
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      w_pop = w_bad;
      for (int o = 0; o < NP; o++) begin
         w_load[o]    = !r_out_valid[o] || !out_full[o];
         w_gnt_v[o]   = 1'b0;
         w_gnt_idx[o] = '0;
         for (int k = 1; k <= NP; k++) begin
            idx = 3'((int'(r_ptr[o]) + k) % NP);
            if (w_load[o] && !w_gnt_v[o] && w_nonempty[idx] && !w_bad[idx] &&
                w_route[idx] == 3'(o)) begin
               w_gnt_v[o]   = 1'b1;
               w_gnt_idx[o] = idx;
            end
         end
         if (w_gnt_v[o]) w_pop[w_gnt_idx[o]] = 1'b1;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NP; p++)
         if (w_push[p]) r_mem[p][r_wr_ptr[p]] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NP; p++) begin
            r_wr_ptr[p] <= '0;
            r_rd_ptr[p] <= '0;
            r_count[p]  <= '0;
         end
         r_overflow  <= '0;
         r_route_err <= 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (w_push[p]) r_wr_ptr[p] <= r_wr_ptr[p] + 1'b1;
            if (w_pop[p])  r_rd_ptr[p] <= r_rd_ptr[p] + 1'b1;
            r_count[p] <= r_count[p] + (PW+1)'(w_push[p]) - (PW+1)'(w_pop[p]);
         end
         r_overflow  <= r_overflow | (in_valid & w_full);
         r_route_err <= r_route_err | (|w_bad);
      end
   end

   // Output registers hold while downstream is full and reload on the transfer cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= '0;
         for (int o = 0; o < NP; o++) r_ptr[o] <= 3'd4;
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (w_gnt_v[o]) begin
               r_out_data[o]  <= w_head[w_gnt_idx[o]];
               r_out_valid[o] <= 1'b1;
               r_ptr[o]       <= w_gnt_idx[o];
            end else if (w_load[o]) begin
               r_out_valid[o] <= 1'b0;
            end
         end
      end
   end

   assign in_full      = w_full;
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign overflow_err = r_overflow;
   assign route_err    = r_route_err;

endmodule

// File: tb/tb_router_mesh_param.sv
// Bench for router_mesh_param: directed scenarios plus random traffic checked
// every cycle against a queue-based reference model.
module tb_router_mesh_param;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [159:0] in_data, out_data, in_data4, out_data4;
   logic [4:0]   in_valid, in_full, out_valid, out_full, overflow_err;
   logic [4:0]   in_valid4, in_full4, out_valid4, out_full4, overflow_err4;
   logic         route_err, route_err4;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] mq [5][$];
   logic [31:0] md [5];
   logic [4:0]  mv, movf;
   logic        mrerr;
   int          mptr [5];

   always #5 clk = ~clk;

   router_mesh_param #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .MESH_X(4), .MESH_Y(2),
                       .ADDR_W(3), .ROUTER_ADDRESS(1)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_full(in_full),
      .out_data(out_data), .out_valid(out_valid), .out_full(out_full),
      .overflow_err(overflow_err), .route_err(route_err));

   router_mesh_param #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .MESH_X(4), .MESH_Y(2),
                       .ADDR_W(4), .ROUTER_ADDRESS(1)) u_dut4 (
      .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_full(in_full4),
      .out_data(out_data4), .out_valid(out_valid4), .out_full(out_full4),
      .overflow_err(overflow_err4), .route_err(route_err4));

   task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Router sits at x=1, y=0 of a 4x2 mesh.
   function automatic int route_of(logic [31:0] f);
      int d, dx, dy;
      d  = int'(f[2:0]);
      dx = d % 4;
      dy = d / 4;
      if (dx > 1) return 1;
      if (dx < 1) return 2;
      if (dy > 0) return 3;
      if (dy < 0) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 5; p++) begin
         mq[p].delete();
         md[p]   = '0;
         mptr[p] = 4;
      end
      mv    = '0;
      movf  = '0;
      mrerr = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently being driven.
   task automatic model_step();
      int       win [5];
      int       idx;
      bit [4:0] popme, full_old, loadable;
      popme = '0;
      for (int p = 0; p < 5; p++) full_old[p] = (mq[p].size() == DEPTH);
      for (int o = 0; o < 5; o++) begin
         win[o]      = -1;
         loadable[o] = !mv[o] || !out_full[o];
         if (loadable[o])
            for (int k = 1; k <= 5; k++) begin
               idx = (mptr[o] + k) % 5;
               if (win[o] < 0 && mq[idx].size() > 0 && route_of(mq[idx][0]) == o) win[o] = idx;
            end
      end
      for (int o = 0; o < 5; o++) begin
         if (win[o] >= 0) begin
            md[o]        = mq[win[o]][0];
            mv[o]        = 1'b1;
            mptr[o]      = win[o];
            popme[win[o]] = 1'b1;
         end else if (loadable[o]) begin
            mv[o] = 1'b0;
         end
      end
      for (int p = 0; p < 5; p++) if (popme[p]) void'(mq[p].pop_front());
      for (int p = 0; p < 5; p++)
         if (in_valid[p]) begin
            if (full_old[p]) movf[p] = 1'b1;
            else mq[p].push_back(in_data[p*32 +: 32]);
         end
   endtask

   task automatic compare_all();
      logic [159:0] exp_data;
      logic [4:0]   exp_full;
      for (int p = 0; p < 5; p++) begin
         exp_data[p*32 +: 32] = md[p];
         exp_full[p]          = (mq[p].size() == DEPTH);
      end
      chk("model_out_valid", 160'(out_valid), 160'(mv));
      chk("model_out_data", out_data, exp_data);
      chk("model_in_full", 160'(in_full), 160'(exp_full));
      chk("model_overflow", 160'(overflow_err), 160'(movf));
      chk("model_route_err", 160'(route_err), 160'(mrerr));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   function automatic int next_src(int s);
      case (s)
         0: return 2;
         2: return 3;
         3: return 4;
         default: return 0;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int src;
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = '0;
      out_full  = '0;
      in_data4  = '0;
      in_valid4 = '0;
      out_full4 = '0;
      model_reset();
      #1;
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_out_data", out_data, 160'(0));
      chk("rst_in_full", 160'(in_full), 160'(0));
      chk("rst_overflow", 160'(overflow_err), 160'(0));
      chk("rst_route_err4", 160'(route_err4), 160'(0));
      @(negedge clk);
      rst = 1'b0;

      // 1: LOCAL flit to dst 3 leaves on X+ after the second edge, for one cycle.
      in_data[31:0] = 32'h0000_0003;
      in_valid      = 5'b00001;
      tick();
      in_valid = '0;
      chk("t1_not_yet", 160'(out_valid), 160'(0));
      tick();
      chk("t1_valid", 160'(out_valid), 160'(5'b00010));
      chk("t1_data", 160'(out_data[63:32]), 160'(32'h0000_0003));
      tick();
      chk("t1_one_cycle", 160'(out_valid), 160'(0));

      // 2: X- and Y+ contend for LOCAL; pointer starts at 4 so X- goes first.
      in_data[95:64]  = 32'hA000_0001;
      in_data[127:96] = 32'hB000_0001;
      in_valid        = 5'b01100;
      tick();
      in_valid = '0;
      tick();
      chk("t2_first_valid", 160'(out_valid), 160'(5'b00001));
      chk("t2_first_data", 160'(out_data[31:0]), 160'(32'hA000_0001));
      tick();
      chk("t2_second_data", 160'(out_data[31:0]), 160'(32'hB000_0001));
      in_data[95:64]  = 32'hC000_0001;
      in_data[127:96] = 32'hD000_0001;
      in_valid        = 5'b01100;
      tick();
      in_valid = '0;
      for (int i = 0; i < 4; i++) tick();

      // 3: X+ blocked downstream while LOCAL streams 10 flits to dst 2.
      out_full = 5'b00010;
      for (int i = 0; i < 10; i++) begin
         in_data[31:0] = (32'(i) << 8) | 32'h2;
         in_valid      = 5'b00001;
         tick();
      end
      in_valid = '0;
      tick();
      chk("t3_hold_data", 160'(out_data[63:32]), 160'(32'h0000_0002));
      chk("t3_in_full", 160'(in_full[0]), 160'(1));
      chk("t3_overflow", 160'(overflow_err[0]), 160'(1));
      out_full = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("t3_stream_valid", 160'(out_valid[1]), 160'(1));
         chk("t3_stream_data", 160'(out_data[63:32]), 160'((32'(k) << 8) | 32'h2));
      end
      tick();
      chk("t3_drained", 160'(out_valid[1]), 160'(0));

      // 4: four inputs stream to dst 1; LOCAL grants must rotate 0,2,3,4.
      prev = -1;
      for (int c = 0; c < 16; c++) begin
         for (int p = 0; p < 5; p++) in_data[p*32 +: 32] = (32'(p) << 28) | (32'(c) << 8) | 32'h1;
         in_valid = 5'b11101;
         tick();
         if (out_valid[0]) begin
            src = int'(out_data[31:28]);
            if (prev >= 0) chk("t4_rotation", 160'(src), 160'(next_src(prev)));
            prev = src;
         end
      end
      in_valid = '0;
      for (int i = 0; i < 40; i++) tick();

      // 5: Y- sends dst 7 (X+ first, XY order) then dst 0 (X-).
      in_data[159:128] = 32'h0000_0007;
      in_valid         = 5'b10000;
      tick();
      in_data[159:128] = 32'h0000_0000;
      tick();
      in_valid = '0;
      chk("t5_xplus_valid", 160'(out_valid), 160'(5'b00010));
      chk("t5_xplus_data", 160'(out_data[63:32]), 160'(32'h0000_0007));
      tick();
      chk("t5_xminus_valid", 160'(out_valid), 160'(5'b00100));
      chk("t5_xminus_data", 160'(out_data[95:64]), 160'(32'h0000_0000));

      // Wider address field: dst 9 is off-mesh and is dropped with route_err.
      in_data4[31:0] = 32'h0000_0009;
      in_valid4      = 5'b00001;
      tick();
      in_data4[31:0] = 32'h0000_0000;
      tick();
      in_valid4 = '0;
      chk("r4_route_err", 160'(route_err4), 160'(1));
      chk("r4_no_output", 160'(out_valid4), 160'(0));
      tick();
      chk("r4_next_valid", 160'(out_valid4), 160'(5'b00100));
      chk("r4_next_data", 160'(out_data4[95:64]), 160'(32'h0000_0000));
      chk("r4_no_overflow", 160'(overflow_err4), 160'(0));

      // Random traffic with intermittent downstream backpressure.
      for (int c = 0; c < 400; c++) begin
         in_valid = 5'($urandom);
         for (int p = 0; p < 5; p++) in_data[p*32 +: 32] = $urandom;
         out_full = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
         tick();
      end
      in_valid = '0;
      out_full = '0;
      for (int i = 0; i < 50; i++) tick();

      // 6: fill LOCAL behind a blocked output, then reset between edges.
      out_full = 5'b11111;
      for (int i = 0; i < 10; i++) begin
         in_data[31:0] = (32'(i) << 8) | 32'h2;
         in_valid      = 5'b00001;
         tick();
      end
      in_valid = '0;
      chk("t6_pre_full", 160'(in_full[0]), 160'(1));
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 160'(out_valid), 160'(0));
      chk("t6_async_full", 160'(in_full), 160'(0));
      chk("t6_async_ovf", 160'(overflow_err), 160'(0));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      out_full = '0;
      #1;
      chk("t6_post_valid", 160'(out_valid), 160'(0));
      in_data[31:0] = 32'h0000_0000;
      in_valid      = 5'b00001;
      tick();
      in_valid = '0;
      chk("t6_not_yet", 160'(out_valid), 160'(0));
      tick();
      chk("t6_xminus_valid", 160'(out_valid), 160'(5'b00100));
      chk("t6_xminus_data", 160'(out_data[95:64]), 160'(32'h0000_0000));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
